// File: rtl/multiplexed_display_driver_if.sv
// Pin-side bundle of the multiplexed 7-segment scanner: frame data and controls in,
// registered segment/digit drive and the frame pulse out.
interface multiplexed_display_driver_if #(
   parameter int NUM_DIGITS      = 4,
   parameter int BRIGHTNESS_BITS = 2
);
   logic [4*NUM_DIGITS-1:0]    data;
   logic [NUM_DIGITS-1:0]      dp;
   logic                       blankLeadingZeros;
   logic                       enable;
   logic [BRIGHTNESS_BITS-1:0] brightness;
   logic [7:0]                 segment;
   logic [NUM_DIGITS-1:0]      digit;
   logic                       frameStart;

   modport master (
      output data, dp, blankLeadingZeros, enable, brightness,
      input  segment, digit, frameStart
   );

   modport slave (
      input  data, dp, blankLeadingZeros, enable, brightness,
      output segment, digit, frameStart
   );
endinterface

// File: rtl/multiplexed_display_driver.sv
// Time-multiplexed hex 7-segment scanner with frame-synchronous data latch,
// leading-zero blanking, PWM brightness and a one-cycle dead time per digit slot.
module multiplexed_display_driver #(
   parameter int NUM_DIGITS         = 4,
   parameter int PRESCALE_BITS      = 17,
   parameter int BRIGHTNESS_BITS    = 2,
   parameter bit SEGMENT_ACTIVE_LOW = 1'b1,
   parameter bit DIGIT_ACTIVE_LOW   = 1'b1
) (
   input logic clock,
   input logic reset,
   multiplexed_display_driver_if.slave bus
);
   localparam int IDX_BITS = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [7:0]            SEG_OFF = {8{SEGMENT_ACTIVE_LOW}};
   localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{DIGIT_ACTIVE_LOW}};

   logic [PRESCALE_BITS-1:0] slotCount;
   logic [IDX_BITS-1:0]      digitIndex;
   logic [4*NUM_DIGITS-1:0]  shadowData;
   logic [NUM_DIGITS-1:0]    shadowDp;
   logic                     shadowBlank;
   logic [7:0]               segmentReg;
   logic [NUM_DIGITS-1:0]    digitReg;
   logic                     frameStartReg;

   logic                  latchNow, lastSlot, lit;
   logic [NUM_DIGITS-1:0] blankMask, oneHot;
   logic [3:0]            curNibble;
   logic                  curDp, curBlank;
   logic [7:0]            segNext;

   function automatic logic [6:0] decode(input logic [3:0] n);
      case (n)
         4'h0: decode = 7'h3F;
         4'h1: decode = 7'h06;
         4'h2: decode = 7'h5B;
         4'h3: decode = 7'h4F;
         4'h4: decode = 7'h66;
         4'h5: decode = 7'h6D;
         4'h6: decode = 7'h7D;
         4'h7: decode = 7'h07;
         4'h8: decode = 7'h7F;
         4'h9: decode = 7'h6F;
         4'hA: decode = 7'h77;
         4'hB: decode = 7'h7C;
         4'hC: decode = 7'h39;
         4'hD: decode = 7'h5E;
         4'hE: decode = 7'h79;
         default: decode = 7'h71;
      endcase
   endfunction

   assign latchNow = (digitIndex == '0) && (slotCount == '0);
   assign lastSlot = (slotCount == '1);

   // Digit i is blanked when it and every higher nibble are zero; digit 0 always shows.
   always_comb begin
      logic allZero;
      allZero   = 1'b1;
      blankMask = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         allZero = allZero && (shadowData[4*i +: 4] == 4'd0);
         blankMask[i] = shadowBlank && (i != 0) && allZero;
      end
   end

   always_comb begin
      curNibble = '0;
      curDp     = 1'b0;
      curBlank  = 1'b0;
      oneHot    = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (digitIndex == IDX_BITS'(i)) begin
            curNibble = shadowData[4*i +: 4];
            curDp     = shadowDp[i];
            curBlank  = blankMask[i];
            oneHot[i] = 1'b1;
         end
      end
   end

   // Slot 0 of each digit is the dead cycle; the top slot bits form the PWM ramp.
   assign lit = bus.enable && (slotCount != '0) &&
                (slotCount[PRESCALE_BITS-1 -: BRIGHTNESS_BITS] <= bus.brightness);
   assign segNext = {curDp, curBlank ? 7'h00 : decode(curNibble)};

   always_ff @(posedge clock) begin
      if (reset) begin
         slotCount     <= '0;
         digitIndex    <= '0;
         shadowData    <= '0;
         shadowDp      <= '0;
         shadowBlank   <= 1'b0;
         frameStartReg <= 1'b0;
         segmentReg    <= SEG_OFF;
         digitReg      <= DIG_OFF;
      end else begin
         slotCount <= slotCount + 1'b1;
         if (lastSlot)
            digitIndex <= (digitIndex == IDX_BITS'(NUM_DIGITS - 1)) ? '0 : digitIndex + 1'b1;
         if (latchNow) begin
            shadowData  <= bus.data;
            shadowDp    <= bus.dp;
            shadowBlank <= bus.blankLeadingZeros;
         end
         frameStartReg <= latchNow;
         segmentReg    <= segNext ^ SEG_OFF;
         digitReg      <= (lit ? oneHot : '0) ^ DIG_OFF;
      end
   end

   assign bus.segment    = segmentReg;
   assign bus.digit      = digitReg;
   assign bus.frameStart = frameStartReg;
endmodule

// File: tb/tb_multiplexed_display_driver.sv
// Directed bench for the 4-digit scanner with a 3-bit prescaler (32-clock frame), active-low pins.
module tb_multiplexed_display_driver;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   multiplexed_display_driver_if #(.NUM_DIGITS(4), .BRIGHTNESS_BITS(2)) bus ();

   multiplexed_display_driver #(
      .NUM_DIGITS(4), .PRESCALE_BITS(3), .BRIGHTNESS_BITS(2),
      .SEGMENT_ACTIVE_LOW(1'b1), .DIGIT_ACTIVE_LOW(1'b1)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus)
   );

   typedef struct {
      logic [15:0]     data;
      logic [3:0]      dp;
      logic            blank;
      logic            en;
      logic [1:0]      br;
      logic [3:0][7:0] seg;   // expected pin value per digit, {d3,d2,d1,d0}
   } vec_t;

   vec_t vecs[8];
   vec_t v1111, v2222;

   task automatic chk(input string nm, input int n, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d got=%h expected=%h", nm, n, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      bus.data              = v.data;
      bus.dp                = v.dp;
      bus.blankLeadingZeros = v.blank;
      bus.enable            = v.en;
      bus.brightness        = v.br;
   endtask

   task automatic check_idle(input string nm, input int n);
      chk({nm, "_digit"}, n, {4'h0, bus.digit}, 8'h0F);
      chk({nm, "_segment"}, n, bus.segment, 8'hFF);
      chk({nm, "_frameStart"}, n, {7'h0, bus.frameStart}, 8'h00);
   endtask

   // Called at a negedge just before the frame-latch edge; checks ncyc cycles of scan.
   task automatic run_frame(input vec_t v, input int ncyc, input int chg_at, input logic [15:0] chg_data);
      int slot, d;
      logic sel;
      logic [3:0] expDig;
      apply(v);
      for (int i = 0; i < ncyc; i++) begin
         @(posedge clock);
         @(negedge clock);
         slot   = i % 8;
         d      = i / 8;
         sel    = v.en && (slot != 0) && ((slot >> 1) <= int'(v.br));
         expDig = sel ? ~(4'b0001 << d) : 4'hF;
         chk("digit", i, {4'h0, bus.digit}, {4'h0, expDig});
         chk("frameStart", i, {7'h0, bus.frameStart}, {7'h0, (i == 0)});
         if (sel) chk("segment", i, bus.segment, v.seg[d]);
         if (i == chg_at) bus.data = chg_data;
      end
   endtask

   initial begin
      vecs[0] = '{16'h1234, 4'b0000, 1'b0, 1'b1, 2'd3, {8'hF9, 8'hA4, 8'hB0, 8'h99}};
      vecs[1] = '{16'h0050, 4'b0010, 1'b1, 1'b1, 2'd3, {8'hFF, 8'hFF, 8'h12, 8'hC0}};
      vecs[2] = '{16'hF0E0, 4'b1000, 1'b1, 1'b1, 2'd3, {8'h0E, 8'hC0, 8'h86, 8'hC0}};
      vecs[3] = '{16'h0000, 4'b0101, 1'b1, 1'b1, 2'd3, {8'hFF, 8'h7F, 8'hFF, 8'h40}};
      vecs[4] = '{16'h0000, 4'b0000, 1'b0, 1'b1, 2'd0, {8'hC0, 8'hC0, 8'hC0, 8'hC0}};
      vecs[5] = '{16'h6789, 4'b0000, 1'b0, 1'b1, 2'd1, {8'h82, 8'hF8, 8'h80, 8'h90}};
      vecs[6] = '{16'hABCD, 4'b0000, 1'b0, 1'b1, 2'd2, {8'h88, 8'h83, 8'hC6, 8'hA1}};
      vecs[7] = '{16'h8888, 4'b1111, 1'b0, 1'b0, 2'd3, {8'h00, 8'h00, 8'h00, 8'h00}};
      v1111   = '{16'h1111, 4'b0000, 1'b0, 1'b1, 2'd3, {8'hF9, 8'hF9, 8'hF9, 8'hF9}};
      v2222   = '{16'h2222, 4'b0000, 1'b0, 1'b1, 2'd3, {8'hA4, 8'hA4, 8'hA4, 8'hA4}};

      apply(vecs[0]);
      reset = 1'b1;
      repeat (3) begin
         @(posedge clock);
         @(negedge clock);
         check_idle("reset_hold", -1);
      end
      reset = 1'b0;

      for (int k = 0; k < 8; k++) run_frame(vecs[k], 32, -1, 16'h0);

      // Data change while digit 2 is lit must not tear the current frame.
      run_frame(v1111, 32, 17, 16'h2222);
      run_frame(v2222, 32, -1, 16'h0);

      // Mid-scan reset while digit 2 is lit, then the scan restarts at digit 0.
      run_frame(vecs[0], 20, -1, 16'h0);
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      check_idle("midscan_reset", 20);
      reset = 1'b0;
      run_frame(vecs[0], 32, -1, 16'h0);
      run_frame(vecs[1], 32, -1, 16'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
